// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the flagged synchronous FIFO.
// Imported by the RTL and by the testbench scoreboard.
package fifo_pkg;

    // Address width needed to index DEPTH entries.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy/pointer width: one extra bit so a full FIFO (count == DEPTH)
    // is representable and the pointers carry a wrap bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when v is a power of two and at least 2.
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // Sticky error flags, kept together so the scoreboard can mirror them.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags. The bench (or the
// surrounding logic) drives the master side; the FIFO is the slave.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) ();
    import fifo_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic                  w_en;
    logic                  r_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, err_clr, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, err_clr, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       i_wrEn,
    input  logic [addr_w(DEPTH)-1:0]   i_wrAddr,
    input  logic [DATA_WIDTH-1:0]      i_wrData,
    input  logic [addr_w(DEPTH)-1:0]   i_rdAddr,
    output logic [DATA_WIDTH-1:0]      o_rdData
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write the incoming word on the edge when the top level accepts it.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, an occupancy
// count, sticky overflow/underflow flags and an optional first-word-fall-
// through read mode. All flags are computed from the next occupancy so they
// change on the same edge as the count.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_flags_if.slave  bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    // Reject illegal configurations while elaborating.
    if (!is_pow2(DEPTH)) begin : g_badDepth
        $fatal(1, "sync_fifo_flags: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_badAf
        $fatal(1, "sync_fifo_flags: AF_THRESH=%0d outside 1..DEPTH", AF_THRESH);
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_badAe
        $fatal(1, "sync_fifo_flags: AE_THRESH=%0d outside 0..DEPTH-1", AE_THRESH);
    end

    // Pointers carry a wrap bit above the address bits.
    logic [CW-1:0]         r_wrPtr;
    logic [CW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almostFull;
    logic                  r_almostEmpty;
    fifo_err_t             r_err;

    logic                  w_wrOk;
    logic                  w_rdOk;
    logic [CW-1:0]         w_countNext;
    fifo_err_t             w_errNext;
    logic [DATA_WIDTH-1:0] w_memRdData;

    // Decide which requests are accepted this cycle. A read needs data
    // already present; a write at full only goes in if a read frees a slot.
    always_comb begin
        w_rdOk      = bus.r_en && !r_empty;
        w_wrOk      = bus.w_en && (!r_full || w_rdOk);
        w_countNext = r_count + CW'(w_wrOk) - CW'(w_rdOk);
    end

    // Sticky error flags: clear request first, then any new rejection
    // this cycle re-sets its flag so an error is never lost.
    always_comb begin
        w_errNext = r_err;
        if (bus.err_clr) begin
            w_errNext = '0;
        end
        if (bus.w_en && !w_wrOk) begin
            w_errNext.overflow = 1'b1;
        end
        if (bus.r_en && !w_rdOk) begin
            w_errNext.underflow = 1'b1;
        end
    end

    // Pointer, occupancy, flag and error state; reset discards all data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_err         <= '0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + CW'(1);
            end
            if (w_rdOk) begin
                r_rdPtr <= r_rdPtr + CW'(1);
            end
            r_count       <= w_countNext;
            r_full        <= (w_countNext == FULL_LVL);
            r_empty       <= (w_countNext == '0);
            r_almostFull  <= (w_countNext >= AF_LVL);
            r_almostEmpty <= (w_countNext <= AE_LVL);
            r_err         <= w_errNext;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_wrOk),
        .i_wrAddr (r_wrPtr[AW-1:0]),
        .i_wrData (bus.data_in),
        .i_rdAddr (r_rdPtr[AW-1:0]),
        .o_rdData (w_memRdData)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word shows straight through; an empty FIFO presents zero.
        always_comb begin
            bus.data_out = r_empty ? '0 : w_memRdData;
        end
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_dataOut;

        // Capture the head word on an accepted read and hold it otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dataOut <= '0;
            end else if (w_rdOk) begin
                r_dataOut <= w_memRdData;
            end
        end

        assign bus.data_out = r_dataOut;
    end

    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almostFull;
    assign bus.almost_empty = r_almostEmpty;
    assign bus.overflow     = r_err.overflow;
    assign bus.underflow    = r_err.underflow;

    // The pointer distance, including the wrap bit, must always equal the
    // separately tracked occupancy.
    a_countMatchesPtrs: assert property (@(posedge clk) disable iff (rst)
        (r_wrPtr - r_rdPtr) == r_count);

endmodule
